// File: rtl/router_pkg.sv
// Shared types and helpers for the 1xN router packet-control FSM.
package router_pkg;

  typedef enum logic [3:0] {
    ST_DECODE_ADDRESS     = 4'd0,
    ST_LOAD_FIRST_DATA    = 4'd1,
    ST_LOAD_DATA          = 4'd2,
    ST_LOAD_PARITY        = 4'd3,
    ST_CHECK_PARITY_ERROR = 4'd4,
    ST_FIFO_FULL_STATE    = 4'd5,
    ST_LOAD_AFTER_FULL    = 4'd6,
    ST_WAIT_TILL_EMPTY    = 4'd7,
    ST_DROP_PACKET        = 4'd8
  } state_e;

  // Timeout counter width; a disabled timeout still needs one bit to exist.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : 32'($clog2(timeout + 1));
  endfunction

endpackage

// File: rtl/router_wait_timer.sv
// Saturating cycle counter for the wait-for-empty state; flags the last allowed cycle.
module router_wait_timer
  import router_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = cnt_width(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_TIMEOUT - 1);
  localparam logic TMO_EN = (WAIT_TIMEOUT != 0);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // expired is registered so it is high exactly while cnt == WAIT_TIMEOUT-1
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt     <= '0;
      expired <= TMO_EN && (CNT_LAST == '0);
    end else if (enable && (cnt != CNT_MAX)) begin
      cnt     <= cnt_inc;
      expired <= TMO_EN && (cnt_inc == CNT_LAST);
    end
  end

endmodule

// File: rtl/router_fsm_n.sv
// Packet-control FSM for the 1xN router: header decode, load sequencing, full stalls,
// invalid-address drop and wait-for-empty timeout.
module router_fsm_n
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned WAIT_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_vld,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] fifo_empty,
  input  logic [NUM_CH-1:0] soft_reset,
  input  logic              fifo_full,
  input  logic              low_pkt_vld,
  input  logic              parity_done,
  output logic [ADDR_W-1:0] addr_q,
  output logic              detect_add,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              write_enb_reg,
  output logic              busy,
  output logic              drop_state,
  output logic              timeout_pulse
);

  localparam int unsigned NUM_ADDR = 1 << ADDR_W;

  state_e state, state_nxt;
  logic [NUM_ADDR-1:0] empty_ext, soft_ext;
  logic addr_invalid, tmr_clear, tmr_enable, tmr_expired;
  logic detect_nxt, lfd_nxt, ld_nxt, laf_nxt, full_nxt, rst_int_nxt;
  logic wen_nxt, busy_nxt, drop_nxt, pulse_nxt;

  // Zero-extend so addresses beyond NUM_CH index a harmless 0 bit.
  assign empty_ext    = NUM_ADDR'(fifo_empty);
  assign soft_ext     = NUM_ADDR'(soft_reset);
  assign addr_invalid = (32'(data_in) >= NUM_CH);
  assign tmr_enable   = (state == ST_WAIT_TILL_EMPTY);
  assign tmr_clear    = (state != ST_WAIT_TILL_EMPTY) && (state_nxt == ST_WAIT_TILL_EMPTY);

  router_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // State, latched address and Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_DECODE_ADDRESS;
      addr_q        <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
      drop_state    <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      if ((state == ST_DECODE_ADDRESS) && pkt_vld) addr_q <= data_in;
      detect_add    <= detect_nxt;
      lfd_state     <= lfd_nxt;
      ld_state      <= ld_nxt;
      laf_state     <= laf_nxt;
      full_state    <= full_nxt;
      rst_int_reg   <= rst_int_nxt;
      write_enb_reg <= wen_nxt;
      busy          <= busy_nxt;
      drop_state    <= drop_nxt;
      timeout_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state != ST_DECODE_ADDRESS) && soft_ext[addr_q]) begin
      state_nxt = ST_DECODE_ADDRESS;
    end else begin
      case (state)
        ST_DECODE_ADDRESS: begin
          if (pkt_vld) begin
            if (addr_invalid)            state_nxt = ST_DROP_PACKET;
            else if (empty_ext[data_in]) state_nxt = ST_LOAD_FIRST_DATA;
            else                         state_nxt = ST_WAIT_TILL_EMPTY;
          end
        end
        ST_LOAD_FIRST_DATA: state_nxt = ST_LOAD_DATA;
        ST_WAIT_TILL_EMPTY: begin
          if (empty_ext[addr_q]) state_nxt = ST_LOAD_FIRST_DATA;
          else if (tmr_expired)  state_nxt = ST_DROP_PACKET;
        end
        ST_LOAD_DATA: begin
          if (fifo_full)     state_nxt = ST_FIFO_FULL_STATE;
          else if (!pkt_vld) state_nxt = ST_LOAD_PARITY;
        end
        ST_LOAD_PARITY: state_nxt = ST_CHECK_PARITY_ERROR;
        ST_CHECK_PARITY_ERROR:
          state_nxt = fifo_full ? ST_FIFO_FULL_STATE : ST_DECODE_ADDRESS;
        ST_FIFO_FULL_STATE: begin
          if (!fifo_full) state_nxt = ST_LOAD_AFTER_FULL;
        end
        ST_LOAD_AFTER_FULL: begin
          if (parity_done)      state_nxt = ST_DECODE_ADDRESS;
          else if (low_pkt_vld) state_nxt = ST_LOAD_PARITY;
          else                  state_nxt = ST_LOAD_DATA;
        end
        ST_DROP_PACKET: begin
          if (!pkt_vld) state_nxt = ST_DECODE_ADDRESS;
        end
        default: state_nxt = ST_DECODE_ADDRESS;
      endcase
    end

    pulse_nxt   = (state == ST_WAIT_TILL_EMPTY) && (state_nxt == ST_DROP_PACKET);
    detect_nxt  = (state_nxt == ST_DECODE_ADDRESS);
    lfd_nxt     = (state_nxt == ST_LOAD_FIRST_DATA);
    ld_nxt      = (state_nxt == ST_LOAD_DATA);
    laf_nxt     = (state_nxt == ST_LOAD_AFTER_FULL);
    full_nxt    = (state_nxt == ST_FIFO_FULL_STATE);
    rst_int_nxt = (state_nxt == ST_CHECK_PARITY_ERROR);
    drop_nxt    = (state_nxt == ST_DROP_PACKET);
    wen_nxt     = ld_nxt || laf_nxt || (state_nxt == ST_LOAD_PARITY);
    busy_nxt    = !(detect_nxt || ld_nxt || drop_nxt);
  end

endmodule

// File: tb/tb_router_fsm_n.sv
// Directed bench for router_fsm_n (NUM_CH=3, ADDR_W=2, WAIT_TIMEOUT=8).
module tb_router_fsm_n;

  logic       clk;
  logic       resetn;
  logic       pkt_vld;
  logic [1:0] data_in;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       fifo_full;
  logic       low_pkt_vld;
  logic       parity_done;
  logic [1:0] addr_q;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy, drop_state, timeout_pulse;

  int checks = 0;
  int errors = 0;

  // {detect, lfd, ld, laf, full, rst_int, wen, busy, drop, timeout}
  localparam logic [9:0] O_DA   = 10'b1000000000;
  localparam logic [9:0] O_LFD  = 10'b0100000100;
  localparam logic [9:0] O_LD   = 10'b0010001000;
  localparam logic [9:0] O_LAF  = 10'b0001001100;
  localparam logic [9:0] O_FULL = 10'b0000100100;
  localparam logic [9:0] O_CPE  = 10'b0000010100;
  localparam logic [9:0] O_LP   = 10'b0000001100;
  localparam logic [9:0] O_WTE  = 10'b0000000100;
  localparam logic [9:0] O_DROP = 10'b0000000010;
  localparam logic [9:0] O_DRPT = 10'b0000000011;

  router_fsm_n #(.NUM_CH(3), .ADDR_W(2), .WAIT_TIMEOUT(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pkt_vld       (pkt_vld),
    .data_in       (data_in),
    .fifo_empty    (fifo_empty),
    .soft_reset    (soft_reset),
    .fifo_full     (fifo_full),
    .low_pkt_vld   (low_pkt_vld),
    .parity_done   (parity_done),
    .addr_q        (addr_q),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .write_enb_reg (write_enb_reg),
    .busy          (busy),
    .drop_state    (drop_state),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [9:0] exp);
    chk(tag, 32'({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                  write_enb_reg, busy, drop_state, timeout_pulse}), 32'(exp));
  endtask

  initial begin
    resetn = 1'b0; pkt_vld = 1'b0; data_in = 2'd0; fifo_empty = 3'b111;
    soft_reset = 3'b000; fifo_full = 1'b0; low_pkt_vld = 1'b0; parity_done = 1'b0;
    cyc(); cyc();
    chk_outs("reset_outs", O_DA);
    chk("reset_addr", 32'(addr_q), 32'd0);
    resetn = 1'b1;
    cyc();
    chk_outs("idle", O_DA);

    // Valid packet to empty channel 2, four payload cycles
    pkt_vld = 1'b1; data_in = 2'd2;
    cyc();
    chk_outs("t1_lfd", O_LFD);
    chk("t1_addr", 32'(addr_q), 32'd2);
    data_in = 2'd1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_outs("t1_ld", O_LD);
    end
    pkt_vld = 1'b0;
    cyc(); chk_outs("t1_lp", O_LP);
    cyc(); chk_outs("t1_cpe", O_CPE);
    cyc(); chk_outs("t1_da", O_DA);
    chk("t1_addr_hold", 32'(addr_q), 32'd2);

    // Channel 1 busy, channel 0 empty must be ignored
    pkt_vld = 1'b1; data_in = 2'd1; fifo_empty = 3'b101;
    cyc(); chk_outs("t2_wte", O_WTE);
    chk("t2_addr", 32'(addr_q), 32'd1);
    data_in = 2'd0;
    for (int i = 0; i < 3; i++) begin
      cyc(); chk_outs("t2_wte_hold", O_WTE);
    end
    fifo_empty = 3'b111;
    cyc(); chk_outs("t2_lfd", O_LFD);
    pkt_vld = 1'b0;
    cyc(); chk_outs("t2_ld", O_LD);
    cyc(); chk_outs("t2_lp", O_LP);
    cyc(); chk_outs("t2_cpe", O_CPE);
    cyc(); chk_outs("t2_da", O_DA);

    // Timeout: 8 cycles waiting on channel 0, then drop with one-cycle pulse
    pkt_vld = 1'b1; data_in = 2'd0; fifo_empty = 3'b110;
    cyc(); chk_outs("t3_wte1", O_WTE);
    for (int i = 0; i < 7; i++) begin
      cyc(); chk_outs("t3_wte", O_WTE);
    end
    cyc(); chk_outs("t3_drop_pulse", O_DRPT);
    cyc(); chk_outs("t3_drop", O_DROP);
    pkt_vld = 1'b0;
    cyc(); chk_outs("t3_da", O_DA);

    // Empty arriving on the expiry cycle wins
    pkt_vld = 1'b1; data_in = 2'd0; fifo_empty = 3'b110;
    cyc(); chk_outs("t3b_wte1", O_WTE);
    for (int i = 0; i < 7; i++) cyc();
    chk_outs("t3b_wte8", O_WTE);
    fifo_empty = 3'b111;
    cyc(); chk_outs("t3b_lfd", O_LFD);
    pkt_vld = 1'b0;
    cyc(); chk_outs("t3b_ld", O_LD);
    cyc(); cyc(); cyc();
    chk_outs("t3b_da", O_DA);

    // Invalid address 3 is dropped without writes or busy
    pkt_vld = 1'b1; data_in = 2'd3;
    cyc(); chk_outs("t4_drop", O_DROP);
    chk("t4_addr", 32'(addr_q), 32'd3);
    cyc(); chk_outs("t4_drop_hold", O_DROP);
    pkt_vld = 1'b0;
    cyc(); chk_outs("t4_da", O_DA);

    // Full stall, release via low_pkt_vld, then parity_done priority
    pkt_vld = 1'b1; data_in = 2'd2;
    cyc(); chk_outs("t5_lfd", O_LFD);
    cyc(); chk_outs("t5_ld", O_LD);
    fifo_full = 1'b1;
    cyc(); chk_outs("t5_full", O_FULL);
    cyc(); chk_outs("t5_full_hold", O_FULL);
    fifo_full = 1'b0; low_pkt_vld = 1'b1;
    cyc(); chk_outs("t5_laf", O_LAF);
    cyc(); chk_outs("t5_lp", O_LP);
    low_pkt_vld = 1'b0; pkt_vld = 1'b0;
    cyc(); chk_outs("t5_cpe", O_CPE);
    fifo_full = 1'b1;
    cyc(); chk_outs("t5_full2", O_FULL);
    fifo_full = 1'b0; parity_done = 1'b1; low_pkt_vld = 1'b1;
    cyc(); chk_outs("t5_laf2", O_LAF);
    cyc(); chk_outs("t5_da", O_DA);
    parity_done = 1'b0; low_pkt_vld = 1'b0;

    // Soft reset only honoured on the latched channel
    pkt_vld = 1'b1; data_in = 2'd2;
    cyc(); chk_outs("t6_lfd", O_LFD);
    cyc(); chk_outs("t6_ld", O_LD);
    soft_reset = 3'b001;
    cyc(); chk_outs("t6_ld_other", O_LD);
    soft_reset = 3'b100;
    cyc(); chk_outs("t6_da", O_DA);
    soft_reset = 3'b000; pkt_vld = 1'b0;
    cyc(); chk_outs("t6_idle", O_DA);

    // resetn mid-packet clears state and address
    pkt_vld = 1'b1; data_in = 2'd1;
    cyc(); chk_outs("t7_lfd", O_LFD);
    resetn = 1'b0; soft_reset = 3'b010;
    cyc(); chk_outs("t7_reset", O_DA);
    chk("t7_addr", 32'(addr_q), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
